// File: rtl/control_unit.sv
// Main opcode decoder of the single-issue MIPS-style datapath; all strobes are registered.
// Optional macro CU_ILLEGAL_OP_EN adds a registered illegalOp flag for unrecognised opcodes.
module control_unit #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    output logic              regDst,
    output logic              branch,
    output logic              memRead,
    output logic              memWrite,
    output logic [ALUOPW-1:0] ALUop,
    output logic              ALUsrc,
    output logic              regWrite,
    output logic              jump,
    output logic              byteOperations,
    output logic              move
`ifdef CU_ILLEGAL_OP_EN
    ,output logic             illegalOp
`endif
);

    localparam logic [ALUOPW-1:0] ALU_ADD  = 3'b000;
    localparam logic [ALUOPW-1:0] ALU_SUB  = 3'b001;
    localparam logic [ALUOPW-1:0] ALU_AND  = 3'b010;
    localparam logic [ALUOPW-1:0] ALU_OR   = 3'b011;
    localparam logic [ALUOPW-1:0] ALU_SLT  = 3'b100;
    localparam logic [ALUOPW-1:0] ALU_SUBN = 3'b101;
    localparam logic [ALUOPW-1:0] ALU_RTYP = 3'b110;
    localparam logic [ALUOPW-1:0] ALU_PASS = 3'b111;

    typedef struct packed {
        logic              reg_dst;
        logic              branch;
        logic              mem_rd;
        logic              mem_wr;
        logic [ALUOPW-1:0] alu_op;
        logic              alu_src;
        logic              reg_wr;
        logic              jump;
        logic              byte_op;
        logic              move;
`ifdef CU_ILLEGAL_OP_EN
        logic              illegal;
`endif
    } ctrl_t;

    ctrl_t ctrl_d, ctrl_q;

    always_comb begin
        ctrl_d = '0;
        case (opcode)
            6'b000000: begin ctrl_d.reg_dst = 1'b1; ctrl_d.reg_wr = 1'b1; ctrl_d.alu_op = ALU_RTYP; end
            6'b000010: begin ctrl_d.alu_src = 1'b1; ctrl_d.reg_wr = 1'b1; ctrl_d.alu_op = ALU_ADD;  end
            6'b000011: begin ctrl_d.alu_src = 1'b1; ctrl_d.reg_wr = 1'b1; ctrl_d.alu_op = ALU_SUB;  end
            6'b000100: begin ctrl_d.alu_src = 1'b1; ctrl_d.reg_wr = 1'b1; ctrl_d.alu_op = ALU_AND;  end
            6'b000101: begin ctrl_d.alu_src = 1'b1; ctrl_d.reg_wr = 1'b1; ctrl_d.alu_op = ALU_OR;   end
            6'b000111: begin ctrl_d.alu_src = 1'b1; ctrl_d.reg_wr = 1'b1; ctrl_d.alu_op = ALU_SLT;  end
            6'b001000, 6'b001001: begin
                ctrl_d.alu_src = 1'b1;
                ctrl_d.mem_rd  = 1'b1;
                ctrl_d.reg_wr  = 1'b1;
                ctrl_d.byte_op = opcode[0];
            end
            6'b010000, 6'b010001: begin
                ctrl_d.alu_src = 1'b1;
                ctrl_d.mem_wr  = 1'b1;
                ctrl_d.byte_op = opcode[0];
            end
            6'b100011: begin ctrl_d.branch = 1'b1; ctrl_d.alu_op = ALU_SUB;  end
            6'b100111: begin ctrl_d.branch = 1'b1; ctrl_d.alu_op = ALU_SUBN; end
            6'b111000: ctrl_d.jump = 1'b1;
            // jal links through the datapath; the decoder only enables the write.
            6'b111001: begin ctrl_d.jump = 1'b1; ctrl_d.reg_wr = 1'b1; end
            6'b100000: begin ctrl_d.move = 1'b1; ctrl_d.reg_wr = 1'b1; ctrl_d.alu_op = ALU_PASS; end
            default: begin
`ifdef CU_ILLEGAL_OP_EN
                ctrl_d.illegal = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= ctrl_d;
    end

    assign regDst         = ctrl_q.reg_dst;
    assign branch         = ctrl_q.branch;
    assign memRead        = ctrl_q.mem_rd;
    assign memWrite       = ctrl_q.mem_wr;
    assign ALUop          = ctrl_q.alu_op;
    assign ALUsrc         = ctrl_q.alu_src;
    assign regWrite       = ctrl_q.reg_wr;
    assign jump           = ctrl_q.jump;
    assign byteOperations = ctrl_q.byte_op;
    assign move           = ctrl_q.move;
`ifdef CU_ILLEGAL_OP_EN
    assign illegalOp      = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit with a scoreboard queue of expected decodes.
module tb_control_unit;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_rd;
        logic       mem_wr;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_wr;
        logic       jump;
        logic       byte_op;
        logic       move;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        exp_t       exp;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       regDst, branch, memRead, memWrite, ALUsrc, regWrite, jump, byteOperations, move;
    logic [2:0] ALUop;
`ifdef CU_ILLEGAL_OP_EN
    logic       illegalOp;
`endif

    control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .regDst(regDst), .branch(branch), .memRead(memRead), .memWrite(memWrite),
        .ALUop(ALUop), .ALUsrc(ALUsrc), .regWrite(regWrite), .jump(jump),
        .byteOperations(byteOperations), .move(move)
`ifdef CU_ILLEGAL_OP_EN
        , .illegalOp(illegalOp)
`endif
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    string nm_q[$];
    vec_t vecs[19];

    function automatic exp_t mk(bit rd, bit br, bit mr, bit mw, logic [2:0] aop,
                                bit as, bit rw, bit j, bit b, bit mv, bit il);
        exp_t e;
        e.reg_dst = rd; e.branch = br; e.mem_rd = mr; e.mem_wr = mw; e.alu_op = aop;
        e.alu_src = as; e.reg_wr = rw; e.jump = j; e.byte_op = b; e.move = mv;
`ifdef CU_ILLEGAL_OP_EN
        e.ill = il;
`else
        e.ill = 1'b0 & il;
`endif
        return e;
    endfunction

    function automatic exp_t snap();
        exp_t a;
        a.reg_dst = regDst; a.branch = branch; a.mem_rd = memRead; a.mem_wr = memWrite;
        a.alu_op = ALUop; a.alu_src = ALUsrc; a.reg_wr = regWrite; a.jump = jump;
        a.byte_op = byteOperations; a.move = move;
`ifdef CU_ILLEGAL_OP_EN
        a.ill = illegalOp;
`else
        a.ill = 1'b0;
`endif
        return a;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (rd br mr mw aop as rw j b mv il)", name, act, exp);
        end
    endtask

    // Drive at negedge, push expectation, then pop/compare at the negedge after the edge.
    task automatic step(input logic r, input logic [5:0] op, input exp_t exp, input string name);
        exp_t e;
        string n;
        rst = r;
        opcode = op;
        sb_q.push_back(exp);
        nm_q.push_back(name);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            check(n, snap(), e);
        end
    endtask

    exp_t zero, addi_e, sw_e;

    initial begin
        zero   = mk(0,0,0,0,3'b000,0,0,0,0,0,0);
        addi_e = mk(0,0,0,0,3'b000,1,1,0,0,0,0);
        sw_e   = mk(0,0,0,1,3'b000,1,0,0,0,0,0);
        vecs[0]  = '{6'b000000, mk(1,0,0,0,3'b110,0,1,0,0,0,0), "rtype"};
        vecs[1]  = '{6'b000010, addi_e,                          "addi"};
        vecs[2]  = '{6'b000011, mk(0,0,0,0,3'b001,1,1,0,0,0,0), "subi"};
        vecs[3]  = '{6'b000100, mk(0,0,0,0,3'b010,1,1,0,0,0,0), "andi"};
        vecs[4]  = '{6'b000101, mk(0,0,0,0,3'b011,1,1,0,0,0,0), "ori"};
        vecs[5]  = '{6'b000111, mk(0,0,0,0,3'b100,1,1,0,0,0,0), "slti"};
        vecs[6]  = '{6'b001000, mk(0,0,1,0,3'b000,1,1,0,0,0,0), "lw"};
        vecs[7]  = '{6'b001001, mk(0,0,1,0,3'b000,1,1,0,1,0,0), "lb"};
        vecs[8]  = '{6'b010000, sw_e,                            "sw"};
        vecs[9]  = '{6'b010001, mk(0,0,0,1,3'b000,1,0,0,1,0,0), "sb"};
        vecs[10] = '{6'b100011, mk(0,1,0,0,3'b001,0,0,0,0,0,0), "beq"};
        vecs[11] = '{6'b100111, mk(0,1,0,0,3'b101,0,0,0,0,0,0), "bne"};
        vecs[12] = '{6'b111000, mk(0,0,0,0,3'b000,0,0,1,0,0,0), "j"};
        vecs[13] = '{6'b111001, mk(0,0,0,0,3'b000,0,1,1,0,0,0), "jal"};
        vecs[14] = '{6'b100000, mk(0,0,0,0,3'b111,0,1,0,0,1,0), "move"};
        vecs[15] = '{6'b000001, mk(0,0,0,0,3'b000,0,0,0,0,0,1), "undef_01"};
        vecs[16] = '{6'b111111, mk(0,0,0,0,3'b000,0,0,0,0,0,1), "undef_3f"};
        vecs[17] = '{6'b000110, mk(0,0,0,0,3'b000,0,0,0,0,0,1), "undef_06"};
        vecs[18] = '{6'b100001, mk(0,0,0,0,3'b000,0,0,0,0,0,1), "undef_21"};

        @(negedge clk);
        // Reset held two edges with lw on the bus, then released.
        step(1'b1, 6'b001000, zero, "reset_edge1");
        step(1'b1, 6'b001000, zero, "reset_edge2");
        step(1'b0, 6'b001000, vecs[6].exp, "lw_after_reset");

        foreach (vecs[i]) step(1'b0, vecs[i].op, vecs[i].exp, vecs[i].name);

        // Reverse order so every output sees both transitions between neighbours.
        for (int i = 18; i >= 0; i--) step(1'b0, vecs[i].op, vecs[i].exp, {vecs[i].name, "_rev"});

        // Mid-stream reset overrides a valid opcode, then decode resumes.
        step(1'b0, 6'b000000, vecs[0].exp, "pre_midrst");
        step(1'b1, 6'b100111, zero, "midrst");
        step(1'b0, 6'b100111, vecs[11].exp, "post_midrst");

        // Latency: opcode change between edges must not reach the outputs early.
        step(1'b0, 6'b000010, addi_e, "lat_addi");
        opcode = 6'b010000;
        #2;
        check("lat_hold", snap(), addi_e);
        @(posedge clk);
        #1;
        check("lat_sw", snap(), sw_e);
        @(negedge clk);

        // Back-to-back random picks from the table.
        for (int k = 0; k < 40; k++) begin
            int idx;
            idx = $urandom_range(0, 18);
            step(1'b0, vecs[idx].op, vecs[idx].exp, {vecs[idx].name, "_rnd"});
        end

        if (sb_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_drain: %0d left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

endmodule
